// File: rtl/apb_regfile_bridge_if.sv
// APB slave-side bus bundle for apb_regfile_bridge.
//   master modport : drives psel/penable/pwrite/paddr/pwdata/pstrb (and pprot), samples response
//   slave modport  : samples request, drives prdata/pready/pslverr
// Optional macro APB_REGFILE_BRIDGE_PROT_EN adds the 3-bit pprot signal.
interface apb_regfile_bridge_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PADDR_W = 12
) ();
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [PADDR_W-1:0]    paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
`ifdef APB_REGFILE_BRIDGE_PROT_EN
    logic [2:0]            pprot;
`endif
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
`ifdef APB_REGFILE_BRIDGE_PROT_EN
        output pprot,
`endif
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
`ifdef APB_REGFILE_BRIDGE_PROT_EN
        input  pprot,
`endif
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_regfile_bridge.sv
// APB slave to register-file bridge with a fixed one-wait-state access.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   apb (slave modport)   APB request/response bundle
//   wr_en/wr_addr/wr_data/wr_be   single-cycle register-file write port
//   rd_addr/rd_data       combinational register-file read port; rd_addr parks at PARK_ADDR
//   err_cnt               saturating count of slave-error responses
// Optional macro APB_REGFILE_BRIDGE_PROT_EN: adds pprot to the bus; unprivileged writes
// (pprot[0]=0) are answered with a slave error.
module apb_regfile_bridge #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       PADDR_W    = 12,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 8'h3F,
    parameter logic [ADDR_W-1:0] PARK_ADDR  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apb_regfile_bridge_if.slave   apb,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_be,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [7:0]            err_cnt
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                write_q;
    logic                err_q;
    logic [DATA_W-1:0]   prdata_q;
    logic [7:0]          err_cnt_q;

    // Request decode, evaluated during the setup phase only.
    logic                setup;
    logic [ADDR_W-1:0]   req_word;
    logic                upper_set;
    logic                req_err;

    assign setup     = apb.psel & ~apb.penable;
    assign req_word  = apb.paddr[ADDR_W+1:2];
    assign upper_set = (apb.paddr >> (ADDR_W + 2)) != '0;

    always_comb begin
        req_err = (apb.paddr[1:0] != 2'b00) | (req_word > ADDR_LIMIT) | upper_set;
`ifdef APB_REGFILE_BRIDGE_PROT_EN
        req_err = req_err | (apb.pwrite & ~apb.pprot[0]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && setup) begin
                addr_q  <= req_word;
                wdata_q <= apb.pwdata;
                strb_q  <= apb.pstrb;
                write_q <= apb.pwrite;
                err_q   <= req_err;
            end
            // Error accesses return zero; good writes leave the read register untouched.
            if (state_q == StExec) begin
                if (err_q) begin
                    prdata_q <= '0;
                end else if (!write_q) begin
                    prdata_q <= rd_data;
                end
            end
            if (state_q == StResp && err_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        rd_addr     = PARK_ADDR;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        unique case (state_q)
            StIdle: begin
                // psel & penable here is a protocol violation and is ignored.
                if (setup) state_d = StExec;
            end
            StExec: begin
                if (!err_q) begin
                    if (write_q) wr_en   = (strb_q != '0);
                    else         rd_addr = addr_q;
                end
                state_d = StResp;
            end
            StResp: begin
                apb.pready  = 1'b1;
                apb.pslverr = err_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign apb.prdata = prdata_q;
    assign wr_addr    = addr_q;
    assign wr_data    = wdata_q;
    assign wr_be      = strb_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
module tb_apb_regfile_bridge;
    localparam int LIMIT = 63;
    localparam logic [7:0] PARK = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    apb_regfile_bridge_if #(.DATA_W(32), .PADDR_W(12)) bus ();

    apb_regfile_bridge dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .apb     (bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .err_cnt (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_val(int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hC3C3_0000;
    endfunction

    // Register file seen by the DUT; every location (including the park address) is non-zero.
    logic [31:0] regs [0:255];
    assign rd_data = regs[rd_addr];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) regs[i] <= init_val(i);
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Reference model state.
    logic [31:0] model [0:LIMIT];
    int          model_cnt;
    logic [31:0] model_prdata;

    typedef struct {logic [31:0] data; logic err; logic [7:0] cnt;} resp_t;
    typedef struct {logic [7:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;
    resp_t       resp_q[$];
    wr_t         wr_q[$];
    logic [7:0]  rd_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= LIMIT; i++) model[i] = init_val(i);
        model_cnt    = 0;
        model_prdata = 32'h0;
    endtask

    // Compute the expected outcome of one access and queue it for the monitors.
    task automatic expect_txn(input logic w, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] p);
        int    word;
        logic  e;
        resp_t r;
        wr_t   x;
        word = int'(a) / 4;
        e    = (int'(a) % 4 != 0) || (word > LIMIT);
`ifdef APB_REGFILE_BRIDGE_PROT_EN
        e = e || (w && !p[0]);
`else
        if (p == 3'b111) e = e; // privilege is not checked in this build
`endif
        r.cnt = 8'(model_cnt);
        r.err = e;
        if (e) begin
            model_cnt    = (model_cnt == 255) ? 255 : model_cnt + 1;
            model_prdata = 32'h0;
        end else if (w) begin
            if (s != 4'h0) begin
                x.addr = 8'(word);
                x.data = d;
                x.be   = s;
                wr_q.push_back(x);
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[word][8*b +: 8] = d[8*b +: 8];
            end
        end else begin
            rd_q.push_back(8'(word));
            model_prdata = model[word];
        end
        r.data = model_prdata;
        resp_q.push_back(r);
    endtask

    task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
        int n;
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = w;
        bus.paddr   = a;
        bus.pwdata  = d;
        bus.pstrb   = s;
`ifdef APB_REGFILE_BRIDGE_PROT_EN
        bus.pprot   = p;
`endif
        expect_txn(w, a, d, s, p);
        @(posedge clk); #1;
        bus.penable = 1'b1;
        n = 1;
        @(negedge clk);
        while (!bus.pready && n < 8) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        chk("pready_latency", 64'(n), 64'd2);
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    // Monitors: pop and compare whenever the DUT presents something.
    always @(negedge clk) begin
        resp_t r;
        wr_t   x;
        if (rst_n) begin
            if (bus.pready) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp actual=pready required=none at %0t", $time);
                end else begin
                    r = resp_q.pop_front();
                    chk("prdata", 64'(bus.prdata), 64'(r.data));
                    chk("pslverr", 64'(bus.pslverr), 64'(r.err));
                    chk("err_cnt", 64'(err_cnt), 64'(r.cnt));
                end
            end else if (bus.pslverr) begin
                chk("pslverr_outside_resp", 64'(bus.pslverr), 64'd0);
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wr_en actual=addr %0h required=none at %0t",
                             wr_addr, $time);
                end else begin
                    x = wr_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(x.addr));
                    chk("wr_data", 64'(wr_data), 64'(x.data));
                    chk("wr_be", 64'(wr_be), 64'(x.be));
                end
            end
            if (rd_addr != PARK) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_addr actual=%0h required=%0h at %0t",
                             rd_addr, PARK, $time);
                end else begin
                    chk("rd_addr", 64'(rd_addr), 64'(rd_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  p;
        int          pready_seen;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
`ifdef APB_REGFILE_BRIDGE_PROT_EN
        bus.pprot = 3'b001;
`endif
        model_reset();
        #12;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wr_be", 64'(wr_be), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'(PARK));
        chk("rst_prdata", 64'(bus.prdata), 64'd0);
        chk("rst_pready", 64'(bus.pready), 64'd0);
        chk("rst_pslverr", 64'(bus.pslverr), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed cases.
        apb(1'b1, 12'h010, 32'hA5A5_0F0F, 4'hF, 3'b001);
        apb(1'b1, 12'h008, 32'h1234_5678, 4'hF, 3'b001);
        apb(1'b0, 12'h008, 32'h0, 4'h0, 3'b001);
        apb(1'b1, 12'h00C, 32'hFFFF_FFFF, 4'h0, 3'b001);
        apb(1'b1, 12'h00C, 32'hDEAD_BEEF, 4'h5, 3'b001);
        apb(1'b0, 12'h00C, 32'h0, 4'h0, 3'b001);
        apb(1'b0, 12'h102, 32'h0, 4'h0, 3'b001);
        apb(1'b0, 12'h200, 32'h0, 4'h0, 3'b001);
        bus_idle();
        @(negedge clk);
        chk("err_cnt_two", 64'(err_cnt), 64'd2);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom);
            case ($urandom_range(0, 8))
                6:       a = 12'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                7:       a = 12'($urandom_range(64, 255) * 4);
                8:       a = 12'($urandom_range(256, 1023) * 4);
                default: a = 12'($urandom_range(0, 63) * 4);
            endcase
            d = $urandom;
            s = 4'($urandom);
            p = 3'($urandom);
            apb(w, a, d, s, p);
        end
        bus_idle();

        // psel dropped after setup: access still completes.
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h020; bus.pwdata = 32'h0BAD_F00D; bus.pstrb = 4'hF;
`ifdef APB_REGFILE_BRIDGE_PROT_EN
        bus.pprot = 3'b001;
`endif
        expect_txn(1'b1, 12'h020, 32'h0BAD_F00D, 4'hF, 3'b001);
        @(posedge clk); #1;
        bus.psel = 1'b0;
        repeat (4) @(posedge clk);
        apb(1'b0, 12'h020, 32'h0, 4'h0, 3'b001);
        bus_idle();

        // psel & penable from idle is ignored.
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = 12'h004;
        pready_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.pready || wr_en) pready_seen++;
        end
        chk("violation_ignored", 64'(pready_seen), 64'd0);
        bus_idle();

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) begin
            a = 12'($urandom_range(64, 1023) * 4);
            apb(1'($urandom), a, $urandom, 4'hF, 3'b001);
        end
        bus_idle();
        @(negedge clk);
        chk("err_cnt_sat", 64'(err_cnt), 64'hFF);

`ifdef APB_REGFILE_BRIDGE_PROT_EN
        apb(1'b1, 12'h010, 32'h5555_AAAA, 4'hF, 3'b000);
        apb(1'b0, 12'h010, 32'h0, 4'h0, 3'b000);
        bus_idle();
`endif

        // Reset during the execute cycle of a write.
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h030; bus.pwdata = 32'h7777_7777; bus.pstrb = 4'hF;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_exec_wr_en", 64'(wr_en), 64'd0);
        chk("rst_exec_rd_addr", 64'(rd_addr), 64'(PARK));
        chk("rst_exec_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_exec_pready", 64'(bus.pready), 64'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            a = 12'($urandom_range(0, 70) * 4);
            apb(1'($urandom), a, $urandom, 4'($urandom), 3'b001);
        end
        bus_idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_regfile_bridge.md
APB_REGFILE_BRIDGE -- requirements
Module: apb_regfile_bridge

Interface
REQ-001 SHALL have parameter DATA_W, 32, APB/regfile data width (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, 8, regfile word-address width.
REQ-003 SHALL have parameter PADDR_W, 12, APB byte-address width (>= ADDR_W+2).
REQ-004 SHALL have parameter ADDR_LIMIT, 8'h3F, highest legal regfile word address.
REQ-005 SHALL have parameter PARK_ADDR, 8'hFF, idle value of rd_addr; must decode to no register.
REQ-006 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports psel, penable, pwrite  in  1 each  APB control.
REQ-009 SHALL have ports paddr  in  PADDR_W, pwdata  in  DATA_W, pstrb  in  DATA_W/8  APB request.
REQ-010 SHALL have ports prdata  out  DATA_W, pready  out  1, pslverr  out  1  APB response.
REQ-011 SHALL have ports wr_en  out  1, wr_addr  out  ADDR_W, wr_data  out  DATA_W, wr_be  out  DATA_W/8  regfile write port.
REQ-012 SHALL have ports rd_addr  out  ADDR_W, rd_data  in  DATA_W  regfile combinational read port.
REQ-013 SHALL have port err_cnt  out  8  saturating count of slave-error responses.

Function
REQ-014 SHALL run an FSM with states IDLE, EXEC, RESP; IDLE after reset.
REQ-015 IDLE: on psel=1 & penable=0, latch paddr/pwdata/pstrb/pwrite and error flag, go to EXEC; else stay.
REQ-016 Error flag SHALL be set when paddr[1:0]!=0 or paddr[ADDR_W+1:2] > ADDR_LIMIT or any paddr bit above ADDR_W+1 is set.
REQ-017 EXEC (one cycle): write, no error, pstrb!=0 -> wr_en=1, wr_addr=latched word address, wr_data/wr_be=latched values; go to RESP.
REQ-018 EXEC read, no error: rd_addr=latched word address; prdata register captures rd_data at end of cycle; go to RESP.
REQ-019 EXEC with error: no wr_en, rd_addr stays PARK_ADDR, prdata register loads 0; go to RESP.
REQ-020 RESP (one cycle): pready=1, pslverr=latched error flag, prdata=register; go to IDLE.
REQ-021 Access latency SHALL be fixed: pready high in the second penable cycle (exactly one wait state), reads and writes alike.
REQ-022 pready and pslverr SHALL be 0 outside RESP; prdata SHALL hold its last value outside RESP.
REQ-023 rd_addr SHALL equal PARK_ADDR in every cycle except a non-error read EXEC cycle, so read-side-effect registers clear only on a real read.
REQ-024 wr_en SHALL be high for exactly one cycle per accepted write; never during reads or error accesses.
REQ-025 Write with pstrb=0 SHALL issue no wr_en, complete normally with pslverr=0.
REQ-026 psel deasserted after latch SHALL NOT abort: the regfile op completes and the FSM returns to IDLE through RESP.
REQ-027 psel=1 & penable=1 in IDLE (protocol violation) SHALL be ignored.
REQ-028 err_cnt SHALL increment in each RESP cycle with pslverr=1 and saturate at 8'hFF.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, wr_en 0, wr_addr 0, wr_data 0, wr_be 0, rd_addr PARK_ADDR, prdata 0, pready 0, pslverr 0, err_cnt 0.
REQ-030 Reset during EXEC SHALL drop the pending op; no wr_en pulse after rst_n release until a new setup phase.

Configuration
REQ-031 With macro APB_REGFILE_BRIDGE_PROT_EN defined, port pprot in 3 SHALL exist; a write with pprot[0]=0 SHALL set the error flag (REQ-019 path).
REQ-032 Without APB_REGFILE_BRIDGE_PROT_EN, no pprot port exists and privilege is never checked.

Verification
REQ-033 Write paddr=12'h010, pwdata=32'hA5A5_0F0F, pstrb=4'hF -> one wr_en pulse, wr_addr=8'h04, wr_be=4'hF; pready in 2nd penable cycle; pslverr=0.
REQ-034 Read paddr=12'h008, rd_data model=32'h1234_5678 -> rd_addr=8'h02 for one cycle only, else 8'hFF; prdata=32'h1234_5678 with pready.
REQ-035 Read paddr=12'h102 (misaligned) and paddr=12'h200 (above limit) -> no wr_en, rd_addr stays 8'hFF, prdata=0, pslverr=1, err_cnt 0->1->2.
REQ-036 Write pstrb=4'h0 -> no wr_en, pslverr=0; write pstrb=4'h5 -> wr_be=4'h5.
REQ-037 rst_n low in EXEC of a write -> wr_en low at once, rd_addr=8'hFF, err_cnt=0; no pulse after release.
REQ-038 260 consecutive error accesses -> err_cnt stays 8'hFF; with PROT_EN, write pprot=3'b000 -> pslverr=1, no wr_en.
